// File: rtl/handshake_pkg.sv
// Shared types and helpers for the constant-check handshake block.
package handshake_pkg;

  // Two-slot output buffer occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_MAX_WIDTH = 32;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] value,
    input logic [SAT_MAX_WIDTH-1:0] max_value
  );
    return (value >= max_value) ? value : value + SAT_MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/handshake_constant_check_if.sv
// Data-in / match-flag-out valid/ready channel pair.
interface handshake_constant_check_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_skid_buffer.sv
// Two-entry in-order skid buffer; in_ready and out_valid come straight from flops.
module handshake_skid_buffer
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  buf_state_t       state;
  logic [WIDTH-1:0] tail;
  logic             accept_c;
  logic             pop_c;

  assign accept_c = in_valid & in_ready;
  assign pop_c    = out_valid & out_ready;

  // Occupancy FSM; head doubles as the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            state     <= ONE;
            out_data  <= in_data;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept_c && !pop_c) begin
            state    <= TWO;
            tail     <= in_data;
            in_ready <= 1'b0;
          end else if (pop_c && !accept_c) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (accept_c && pop_c) begin
            out_data <= in_data;
          end
        end
        TWO: begin
          if (pop_c) begin
            state    <= ONE;
            out_data <= tail;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/handshake_constant_check.sv
// Sink that compares each accepted token to EXPECTED, emits a match flag
// per token and keeps saturating match/mismatch statistics.
// CNT_WIDTH must not exceed handshake_pkg::SAT_MAX_WIDTH.
module handshake_constant_check
  import handshake_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED   = '0,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  handshake_constant_check_if.slave        bus,
  input  logic                             clear,
  output logic                             mismatch_seen,
  output logic [DATA_WIDTH-1:0]            first_bad,
  output logic [CNT_WIDTH-1:0]             match_cnt,
  output logic [CNT_WIDTH-1:0]             mismatch_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic match_c;
  logic accept_c;

  assign match_c  = (bus.ins == EXPECTED);
  assign accept_c = bus.ins_valid & bus.ins_ready;

  handshake_skid_buffer #(
    .WIDTH (1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (match_c),
    .in_valid  (bus.ins_valid),
    .in_ready  (bus.ins_ready),
    .out_data  (bus.outs),
    .out_valid (bus.outs_valid),
    .out_ready (bus.outs_ready)
  );

  // Statistics on accepted beats; clear wins over the same-cycle update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_seen <= 1'b0;
      first_bad     <= '0;
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
    end else if (clear) begin
      mismatch_seen <= 1'b0;
      first_bad     <= '0;
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
    end else if (accept_c) begin
      if (match_c) begin
        match_cnt <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(match_cnt), SAT_MAX_WIDTH'(CNT_MAX)));
      end else begin
        mismatch_cnt <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(mismatch_cnt), SAT_MAX_WIDTH'(CNT_MAX)));
        if (!mismatch_seen) begin
          first_bad     <= bus.ins;
          mismatch_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_handshake_constant_check.sv
// Directed + randomized bench for handshake_constant_check with a queue-based model.
module tb_handshake_constant_check;

  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 4;
  localparam logic [7:0]  EXP    = 8'hA5;
  localparam int          CNTMAX = 15;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          mismatch_seen;
  logic [DW-1:0] first_bad;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] mismatch_cnt;

  handshake_constant_check_if #(.DATA_WIDTH(DW)) bus ();

  handshake_constant_check #(
    .DATA_WIDTH (DW),
    .EXPECTED   (EXP),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .clear         (clear),
    .mismatch_seen (mismatch_seen),
    .first_bad     (first_bad),
    .match_cnt     (match_cnt),
    .mismatch_cnt  (mismatch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending match flags in order, plus plain statistics.
  bit         q[$];
  int         m_match;
  int         m_mismatch;
  bit         m_seen;
  logic [7:0] m_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_match    = 0;
    m_mismatch = 0;
    m_seen     = 1'b0;
    m_first    = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".outs_valid"}, 32'(bus.outs_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk({tag, ".outs"}, 32'(bus.outs), 32'(q[0]));
    chk({tag, ".ins_ready"}, 32'(bus.ins_ready), 32'(q.size() < 2));
    chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(m_match));
    chk({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_mismatch));
    chk({tag, ".mismatch_seen"}, 32'(mismatch_seen), 32'(m_seen));
    chk({tag, ".first_bad"}, 32'(first_bad), 32'(m_first));
  endtask

  // One clock: drive at negedge, check current outputs, advance model and DUT.
  task automatic cycle(input bit vin, input logic [7:0] din, input bit ordy,
                       input bit clr, input string tag);
    bit acc;
    bit pop;
    bus.ins_valid  = vin;
    bus.ins        = din;
    bus.outs_ready = ordy;
    clear          = clr;
    check_outputs(tag);
    acc = vin && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(din == EXP);
    if (clr) begin
      m_match    = 0;
      m_mismatch = 0;
      m_seen     = 1'b0;
      m_first    = 8'h00;
    end else if (acc) begin
      if (din == EXP) begin
        m_match = (m_match < CNTMAX) ? m_match + 1 : CNTMAX;
      end else begin
        m_mismatch = (m_mismatch < CNTMAX) ? m_mismatch + 1 : CNTMAX;
        if (!m_seen) begin
          m_seen  = 1'b1;
          m_first = din;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] stream [4];
    stream[0] = 8'hA5; stream[1] = 8'h3C; stream[2] = 8'hA5; stream[3] = 8'hFF;

    clk            = 1'b0;
    rst            = 1'b0;
    clear          = 1'b0;
    bus.ins        = EXP;
    bus.ins_valid  = 1'b1;   // must be ignored while in reset
    bus.outs_ready = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset.outs", 32'(bus.outs), 32'd0);
    rst = 1'b1;

    // Single matching token.
    cycle(1'b1, EXP, 1'b1, 1'b0, "single_in");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_out");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_idle");

    // Back-to-back mixed stream.
    for (int i = 0; i < 4; i++) cycle(1'b1, stream[i], 1'b1, 1'b0, "stream");
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, "stream_drain");

    // Backpressure: fill both slots, stall, then drain.
    repeat (4) cycle(1'b1, EXP, 1'b0, 1'b0, "bp_fill");
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0, "bp_drain");

    // Saturation of match counter from a cleared start.
    cycle(1'b0, 8'h00, 1'b1, 1'b1, "sat_clear");
    repeat (17) cycle(1'b1, EXP, 1'b1, 1'b0, "sat");
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0, "sat_drain");
    chk("sat.match_cnt_final", 32'(match_cnt), 32'd15);
    chk("sat.mismatch_cnt_final", 32'(mismatch_cnt), 32'd0);

    // Clear coincident with a mismatching accept.
    cycle(1'b1, 8'h3C, 1'b1, 1'b1, "clr_accept");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "clr_emit");
    chk("clr.mismatch_seen", 32'(mismatch_seen), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "clr_idle");

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      bit         v;
      bit         r;
      bit         c;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) == 1) ? EXP : 8'($urandom);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 31) == 0);
      cycle(v, d, r, c, "rand");
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, "rand_drain");

    // Asynchronous reset with two tokens buffered.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "areset_pre");
    cycle(1'b1, 8'h11, 1'b0, 1'b0, "areset_fill");
    cycle(1'b1, EXP, 1'b0, 1'b0, "areset_fill");
    chk("areset.full", 32'(bus.ins_ready), 32'd0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("areset.outs_valid_now", 32'(bus.outs_valid), 32'd0);
    check_outputs("areset_now");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, "areset_after");
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, "post_reset_in");
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_reset_out");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_constant_check.md
Name: handshake_constant_check

Overview:
- Dataflow sink/checker: the consuming end of a constant-source channel.
- Accepts data tokens on a valid/ready input channel and compares each token against a compile-time expected constant.
- Emits one control token per input token on a valid/ready output channel, carrying a 1-bit match flag.
- Keeps saturating match/mismatch statistics and captures the first offending value. Used at constant-channel boundaries and in self-checking dataflow test harnesses.

Parameters:
- DATA_WIDTH, 32, width of the input data token.
- EXPECTED, 0, expected constant value. DATA_WIDTH bits; only the low DATA_WIDTH bits are used.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- ins  in  DATA_WIDTH  input data token
- ins_valid  in  1  input token valid
- ins_ready  out  1  input token accepted when ins_valid & ins_ready
- outs  out  1  output token payload: 1 = token matched EXPECTED, 0 = mismatch
- outs_valid  out  1  output token valid
- outs_ready  in  1  downstream ready
- clear  in  1  synchronous clear of statistics and sticky state
- mismatch_seen  out  1  sticky: a mismatch has been accepted since reset/clear
- first_bad  out  DATA_WIDTH  value of first mismatching token since reset/clear
- match_cnt  out  CNT_WIDTH  accepted matching tokens, saturating
- mismatch_cnt  out  CNT_WIDTH  accepted mismatching tokens, saturating

Behaviour:
- Reset (rst=0, async):
  - Buffer state EMPTY; outs_valid=0, outs=0, ins_ready=1.
  - mismatch_seen=0, first_bad=0, match_cnt=0, mismatch_cnt=0.
  - ins_valid is ignored while rst=0.
- Accept = ins_valid & ins_ready. Pop = outs_valid & outs_ready.
- Match bit m = (ins == EXPECTED[DATA_WIDTH-1:0]), evaluated at accept.
- Output buffer: two-slot skid buffer holding m bits, in order. States:
  - EMPTY: accept -> ONE (head=m).
  - ONE:
    - accept & !pop -> TWO (tail=m).
    - pop & !accept -> EMPTY.
    - accept & pop -> ONE (head=m).
  - TWO: pop -> ONE (head=tail). Accept is impossible because ins_ready=0.
- ins_ready = (state != TWO). It depends on registered state only, with no combinational path from outs_ready.
- outs_valid = (state != EMPTY); outs = head.
- Latency: token accepted at edge N appears on outs_valid/outs after edge N, when the buffer was EMPTY.
- Sustained throughput: 1 token/cycle when outs_ready=1.
- Backpressure: outs_ready=0 holds outs/outs_valid stable. After two accepts, ins_ready drops.
- Statistics update on accept only:
  - m=1: match_cnt += 1, saturating at all-ones.
  - m=0: mismatch_cnt += 1, saturating; if mismatch_seen=0, first_bad <= ins and mismatch_seen <= 1.
- clear=1 takes priority over the statistics update in the same cycle:
  - All statistics go to 0; the beat accepted that cycle is not counted.
  - Token flow and buffer state are unaffected by clear.
- Counter at all-ones plus an accept of its kind holds all-ones; the other counter is unaffected.
- Reset asserted mid-stream: buffered tokens are discarded; no partial token is emitted after reset release.

Decomposition:
- handshake_pkg:
  - Buffer state encoding localparams (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
  - Saturating-increment function.
- Sub-module handshake_skid_buffer (parameter WIDTH=1): the two-slot buffer with the same rst semantics.
- Top level holds the comparator and statistics.

Test Plan (DATA_WIDTH=8, EXPECTED=8'hA5, CNT_WIDTH=4 unless stated):
- Reset release, then ins=A5 valid one cycle, outs_ready=1 -> outs_valid=1, outs=1 the next cycle only; match_cnt=1, mismatch_cnt=0.
- Stream A5,3C,A5,FF back-to-back, outs_ready=1 -> outs sequence 1,0,1,0 on consecutive cycles; mismatch_seen=1, first_bad=3C, match_cnt=2, mismatch_cnt=2.
- outs_ready=0, offer A5 every cycle -> two accepts, then ins_ready=0 and outs held at 1. Raise outs_ready -> both tokens drain in order, ins_ready returns to 1 the cycle after the first pop.
- 17 consecutive A5 tokens -> match_cnt saturates at 4'hF; mismatch_cnt stays 0.
- clear=1 in the same cycle as accepting 3C -> the token is still emitted with outs=0; mismatch_cnt=0, mismatch_seen=0, first_bad=0 afterwards.
- Two tokens buffered (outs_ready=0), then rst pulsed low asynchronously -> outs_valid=0 immediately. After release, no stale tokens, ins_ready=1, all counters 0.
